// File: rtl/heartbeat_rx_monitor.sv
// heartbeat_rx_monitor
// Decodes periodic 64-bit heartbeat frames into registered status fields.
// Tracks link health with a millisecond silence timer and decodes the
// fast-shutter action message.
//
// Link states:
//   IDLE  - no heartbeat seen since reset (never times out)
//   ALIVE - heartbeats arriving
//   LOST  - TIMEOUT_MS of silence while ALIVE
//
// Ports:
//   clk_i, rst_i (sync, active high)
//   heartbeat_en_i / heartbeat_data_i   - heartbeat frame strobe + payload
//   message_up_i / message_up_data_i    - action message strobe + payload
//   *_o status fields                   - last accepted heartbeat, held between frames
//   status_valid_o                      - pulse per decoded heartbeat
//   link_alive_o / link_lost_o          - ALIVE level / ALIVE->LOST pulse
//   heartbeat_cnt_o                     - accepted heartbeats, wraps
//   fast_shutter_set_o / _upd_o         - shutter command + update pulse
//   frame_err_cnt_o                     - rejected frames, saturating
//
// Build option: define HEARTBEAT_RESERVED_CHECK_EN to reject heartbeats with
// nonzero reserved bits [63:35].
module heartbeat_rx_monitor #(
    parameter real TCQ        = 0.1,
    parameter int  CLK_PER_MS = 100000,
    parameter int  TIMEOUT_MS = 1500
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        heartbeat_en_i,
    input  logic [63:0] heartbeat_data_i,
    input  logic        message_up_i,
    input  logic [63:0] message_up_data_i,
    output logic [3:0]  scan_state_o,
    output logic        fast_shutter_state_o,
    output logic [2:0]  pmt_scan_en_o,
    output logic [2:0]  fbc_motor_state_o,
    output logic        laser_control_o,
    output logic        laser_out_switch_o,
    output logic [11:0] laser_aom_voltage_o,
    output logic        eds_power_en_o,
    output logic        eds_frame_en_o,
    output logic [3:0]  map_readback_cnt_o,
    output logic [3:0]  main_scan_cnt_o,
    output logic        status_valid_o,
    output logic        link_alive_o,
    output logic        link_lost_o,
    output logic [15:0] heartbeat_cnt_o,
    output logic        fast_shutter_set_o,
    output logic        fast_shutter_upd_o,
    output logic [7:0]  frame_err_cnt_o
);

    localparam int MSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int SLW = $clog2(TIMEOUT_MS + 1);
    localparam logic [MSW-1:0] MS_LAST   = MSW'(CLK_PER_MS - 1);
    localparam logic [SLW-1:0] SIL_MAX   = SLW'(TIMEOUT_MS);
    localparam logic [SLW-1:0] SIL_FINAL = SLW'(TIMEOUT_MS - 1);

    // Field order mirrors heartbeat_data_i[34:0], MSB first.
    typedef struct packed {
        logic [3:0]  map_readback_cnt;
        logic [3:0]  main_scan_cnt;
        logic [3:0]  scan_state;
        logic        fast_shutter_state;
        logic [2:0]  pmt_scan_en;
        logic [2:0]  fbc_motor_state;
        logic        laser_control;
        logic        laser_out_switch;
        logic [11:0] laser_aom_voltage;
        logic        eds_power_en;
        logic        eds_frame_en;
    } hb_fields_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIVE = 2'd1,
        LOST  = 2'd2
    } link_state_t;

    hb_fields_t  fields;
    link_state_t state, state_nxt;
    logic [MSW-1:0] ms_cnt;
    logic [SLW-1:0] silence;
    logic tick, hb_ok, hb_err, msg_ok, msg_err, timeout_hit;

`ifdef HEARTBEAT_RESERVED_CHECK_EN
    logic rsvd_bad;
    assign rsvd_bad = |heartbeat_data_i[63:35];
    assign hb_ok    = heartbeat_en_i & ~rsvd_bad;
    assign hb_err   = heartbeat_en_i &  rsvd_bad;
`else
    wire unused_rsvd = ^heartbeat_data_i[63:35];
    assign hb_ok  = heartbeat_en_i;
    assign hb_err = 1'b0;
`endif

    wire unused_msg = ^message_up_data_i[55:1];

    assign msg_ok  = message_up_i & (message_up_data_i[63:56] == 8'd1);
    assign msg_err = message_up_i & (message_up_data_i[63:56] != 8'd1);

    assign tick = (ms_cnt == MS_LAST);
    // This tick moves silence onto the timeout value.
    assign timeout_hit = tick & (silence == SIL_FINAL);

    // Link state machine; an accepted heartbeat always wins over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hb_ok) state_nxt = ALIVE;
            ALIVE:   if (!hb_ok && timeout_hit) state_nxt = LOST;
            LOST:    if (hb_ok) state_nxt = ALIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    assign link_alive_o = (state == ALIVE);

    // ms prescaler and silence timer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ms_cnt  <= '0;
            silence <= '0;
        end else begin
            ms_cnt <= tick ? '0 : ms_cnt + 1'b1;
            if (hb_ok)
                silence <= '0;
            else if (tick && silence != SIL_MAX)
                silence <= silence + 1'b1;
        end
    end

    // Heartbeat decode, counters, action message
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fields             <= '0;
            status_valid_o     <= 1'b0;
            link_lost_o        <= 1'b0;
            heartbeat_cnt_o    <= '0;
            fast_shutter_set_o <= 1'b0;
            fast_shutter_upd_o <= 1'b0;
            frame_err_cnt_o    <= '0;
        end else begin
            status_valid_o     <= hb_ok;
            link_lost_o        <= (state == ALIVE) && (state_nxt == LOST);
            fast_shutter_upd_o <= msg_ok;
            if (hb_ok) begin
                fields          <= hb_fields_t'(heartbeat_data_i[34:0]);
                heartbeat_cnt_o <= heartbeat_cnt_o + 1'b1;
            end
            if (msg_ok)
                fast_shutter_set_o <= message_up_data_i[0];
            // Simultaneous errors count once.
            if ((hb_err || msg_err) && frame_err_cnt_o != 8'hFF)
                frame_err_cnt_o <= frame_err_cnt_o + 1'b1;
        end
    end

    assign map_readback_cnt_o   = fields.map_readback_cnt;
    assign main_scan_cnt_o      = fields.main_scan_cnt;
    assign scan_state_o         = fields.scan_state;
    assign fast_shutter_state_o = fields.fast_shutter_state;
    assign pmt_scan_en_o        = fields.pmt_scan_en;
    assign fbc_motor_state_o    = fields.fbc_motor_state;
    assign laser_control_o      = fields.laser_control;
    assign laser_out_switch_o   = fields.laser_out_switch;
    assign laser_aom_voltage_o  = fields.laser_aom_voltage;
    assign eds_power_en_o       = fields.eds_power_en;
    assign eds_frame_en_o       = fields.eds_frame_en;

endmodule

// File: tb/tb_heartbeat_rx_monitor.sv
// Directed bench for heartbeat_rx_monitor with CLK_PER_MS=10, TIMEOUT_MS=5.
// Honors HEARTBEAT_RESERVED_CHECK_EN the same way as the design.
module tb_heartbeat_rx_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hb_en = 1'b0;
    logic [63:0] hb_data = '0;
    logic        msg_en = 1'b0;
    logic [63:0] msg_data = '0;
    logic [3:0]  scan_state, map_cnt, main_cnt;
    logic        fs_state, laser_ctl, laser_sw, eds_pwr, eds_frm;
    logic [2:0]  pmt, fbc;
    logic [11:0] aom;
    logic        sv, alive, lost, fs_set, fs_upd;
    logic [15:0] hb_cnt;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] HB_A = 64'h0000_0004_8F8A_BFFF;

    always #5 clk = ~clk;

    heartbeat_rx_monitor #(.CLK_PER_MS(10), .TIMEOUT_MS(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .heartbeat_en_i(hb_en), .heartbeat_data_i(hb_data),
        .message_up_i(msg_en), .message_up_data_i(msg_data),
        .scan_state_o(scan_state), .fast_shutter_state_o(fs_state),
        .pmt_scan_en_o(pmt), .fbc_motor_state_o(fbc),
        .laser_control_o(laser_ctl), .laser_out_switch_o(laser_sw),
        .laser_aom_voltage_o(aom), .eds_power_en_o(eds_pwr),
        .eds_frame_en_o(eds_frm), .map_readback_cnt_o(map_cnt),
        .main_scan_cnt_o(main_cnt), .status_valid_o(sv),
        .link_alive_o(alive), .link_lost_o(lost),
        .heartbeat_cnt_o(hb_cnt), .fast_shutter_set_o(fs_set),
        .fast_shutter_upd_o(fs_upd), .frame_err_cnt_o(err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs set before the call are sampled on it,
    // outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " fields"}, {map_cnt, main_cnt, scan_state, fs_state, pmt, fbc,
                               laser_ctl, laser_sw, aom, eds_pwr, eds_frm}, 64'd0);
        chk({tag, " sv"}, sv, 0);
        chk({tag, " alive"}, alive, 0);
        chk({tag, " lost"}, lost, 0);
        chk({tag, " hb_cnt"}, hb_cnt, 0);
        chk({tag, " fs"}, {fs_set, fs_upd}, 0);
        chk({tag, " err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        int lost_pulses;
        int lost_at;
        logic [7:0] e0;

        // reset: edges E1,E2
        step(); step();
        rst = 1'b0;
        check_all_zero("reset");

        // decode at E3
        hb_data = HB_A; hb_en = 1'b1; step(); hb_en = 1'b0;
        chk("dec map", map_cnt, 9);
        chk("dec main", main_cnt, 1);
        chk("dec scan", scan_state, 15);
        chk("dec aom", aom, 12'hFFF);
        chk("dec misc", {fs_state, pmt, fbc, laser_ctl, laser_sw, eds_pwr, eds_frm},
            {1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1});
        chk("dec sv", sv, 1);
        chk("dec alive", alive, 1);
        chk("dec hb_cnt", hb_cnt, 1);
        hb_data = '0;
        step();
        chk("hold sv", sv, 0);
        chk("hold map", map_cnt, 9);

        // silence: ticks at E12,22,32,42,52 -> lost pulse after E52 (i=49)
        lost_pulses = 0; lost_at = -1;
        for (int i = 2; i <= 60; i++) begin
            step();
            if (lost) begin lost_pulses++; if (lost_at < 0) lost_at = i; end
            if (i == 48) chk("alive before timeout", alive, 1);
        end
        chk("lost pulses", lost_pulses, 1);
        chk("lost cycle", lost_at, 49);
        chk("lost alive", alive, 0);

        // recover at E64
        hb_data = HB_A; hb_en = 1'b1; step(); hb_en = 1'b0;
        chk("recover alive", alive, 1);
        chk("recover hb_cnt", hb_cnt, 2);

        // ticks at E72..E112; heartbeat lands on the 5th (E112)
        lost_pulses = 0;
        for (int i = 65; i <= 111; i++) begin
            step();
            if (lost) lost_pulses++;
        end
        chk("pre-prio alive", alive, 1);
        hb_en = 1'b1; step(); hb_en = 1'b0;
        if (lost) lost_pulses++;
        chk("prio lost", lost_pulses, 0);
        chk("prio alive", alive, 1);
        chk("prio hb_cnt", hb_cnt, 3);
        step();
        chk("prio lost after", lost, 0);
        chk("prio alive after", alive, 1);

        // reset while ALIVE, with a heartbeat strobed in the same cycle
        rst = 1'b1; hb_en = 1'b1; step(); rst = 1'b0; hb_en = 1'b0;
        check_all_zero("midreset");
        lost_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (lost || alive) lost_pulses++;
        end
        chk("idle no timeout", lost_pulses, 0);

        // action messages
        msg_data = 64'h0100_0000_0000_0001; msg_en = 1'b1; step(); msg_en = 1'b0;
        chk("msg set", fs_set, 1);
        chk("msg upd", fs_upd, 1);
        step();
        chk("msg upd clr", fs_upd, 0);
        msg_data = 64'h0200_0000_0000_0000; msg_en = 1'b1; step(); msg_en = 1'b0;
        chk("badmsg upd", fs_upd, 0);
        chk("badmsg set", fs_set, 1);
        chk("badmsg err", err_cnt, 1);

        // both strobes together, handled independently
        hb_data = HB_A; hb_en = 1'b1;
        msg_data = 64'h0100_0000_0000_0000; msg_en = 1'b1;
        step(); hb_en = 1'b0; msg_en = 1'b0;
        chk("both sv", sv, 1);
        chk("both hb_cnt", hb_cnt, 1);
        chk("both set", fs_set, 0);
        chk("both upd", fs_upd, 1);

        // reserved bit 63 set, fields would otherwise go to zero
        hb_data = 64'h8000_0000_0000_0000; hb_en = 1'b1; step(); hb_en = 1'b0;
`ifdef HEARTBEAT_RESERVED_CHECK_EN
        chk("rsvd sv", sv, 0);
        chk("rsvd map", map_cnt, 9);
        chk("rsvd hb_cnt", hb_cnt, 1);
        chk("rsvd err", err_cnt, 2);
`else
        chk("rsvd sv", sv, 1);
        chk("rsvd map", map_cnt, 0);
        chk("rsvd hb_cnt", hb_cnt, 2);
        chk("rsvd err", err_cnt, 1);
`endif

        // bad heartbeat + bad message in one cycle: one increment at most
        e0 = err_cnt;
        msg_data = 64'h0300_0000_0000_0000; msg_en = 1'b1; hb_en = 1'b1;
        step(); msg_en = 1'b0; hb_en = 1'b0;
        chk("dual err", err_cnt, e0 + 8'd1);

        // saturation
        msg_en = 1'b1;
        for (int i = 0; i < 260; i++) step();
        msg_en = 1'b0;
        chk("err sat", err_cnt, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/heartbeat_rx_monitor.md
HEARTBEAT_RX_MONITOR -- requirements
Module: heartbeat_rx_monitor

Interface
REQ-001 SHALL have parameters (name, default, meaning): TCQ, 0.1, register update delay; CLK_PER_MS, 100000, clk_i cycles per 1 ms tick; TIMEOUT_MS, 1500, heartbeat silence (ms) before link declared lost.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-high reset.
- heartbeat_en_i, in, 1, one-cycle heartbeat frame strobe.
- heartbeat_data_i, in, 64, heartbeat frame.
- message_up_i, in, 1, one-cycle action message strobe.
- message_up_data_i, in, 64, action message.
- scan_state_o, out, 4.
- fast_shutter_state_o, out, 1.
- pmt_scan_en_o, out, 3.
- fbc_motor_state_o, out, 3.
- laser_control_o, out, 1.
- laser_out_switch_o, out, 1.
- laser_aom_voltage_o, out, 12.
- eds_power_en_o, out, 1.
- eds_frame_en_o, out, 1.
- map_readback_cnt_o, out, 4.
- main_scan_cnt_o, out, 4.
- status_valid_o, out, 1, one-cycle pulse on each decoded heartbeat.
- link_alive_o, out, 1, high in ALIVE state.
- link_lost_o, out, 1, one-cycle pulse on ALIVE->LOST.
- heartbeat_cnt_o, out, 16, accepted heartbeats, wraps.
- fast_shutter_set_o, out, 1, last decoded shutter command.
- fast_shutter_upd_o, out, 1, one-cycle pulse on valid action message.
- frame_err_cnt_o, out, 8, rejected frames, saturating.

Function
REQ-003 SHALL decode heartbeat_data_i as: [63:35] reserved zero, [34:31] map_readback_cnt, [30:27] main_scan_cnt, [26:23] scan_state, [22] fast_shutter_state, [21:19] pmt_scan_en, [18:16] fbc_motor_state, [15] laser_control, [14] laser_out_switch, [13:2] laser_aom_voltage, [1] eds_power_en, [0] eds_frame_en.
REQ-004 SHALL register all decoded fields and assert status_valid_o exactly 1 cycle after an accepted heartbeat_en_i; fields hold between frames.
REQ-005 SHALL generate an internal 1 ms tick: counter 0..CLK_PER_MS-1, tick pulse on wrap.
REQ-006 SHALL keep a silence counter in ms, cleared on every accepted heartbeat, incremented per tick, saturating at TIMEOUT_MS.
REQ-007 SHALL implement states IDLE (no heartbeat since reset), ALIVE, LOST; IDLE->ALIVE and LOST->ALIVE on accepted heartbeat; ALIVE->LOST when silence counter reaches TIMEOUT_MS; IDLE never times out.
REQ-008 SHALL give heartbeat priority when an accepted heartbeat and the timeout-reaching tick occur in the same cycle: stay/enter ALIVE, no link_lost_o pulse.
REQ-009 SHALL pulse link_lost_o once per ALIVE->LOST transition, 1 cycle after the timeout-reaching tick.
REQ-010 SHALL increment heartbeat_cnt_o per accepted heartbeat, wrapping 0xFFFF->0x0000.
REQ-011 SHALL accept an action message only when message_up_data_i[63:56]==8'd1; then fast_shutter_set_o <= bit[0] and fast_shutter_upd_o pulses, both 1 cycle after message_up_i; other type codes are ignored and increment frame_err_cnt_o.
REQ-012 SHALL process heartbeat_en_i and message_up_i independently when both arrive in one cycle.
REQ-013 SHALL saturate frame_err_cnt_o at 8'hFF; one increment per cycle when both frame types error simultaneously.

Reset
REQ-014 SHALL, on rst_i high at a clock edge, clear all outputs, counters and ms prescaler to 0 and enter IDLE; reset mid-operation discards any frame strobed in the same cycle.

Configuration
REQ-015 SHALL support macro HEARTBEAT_RESERVED_CHECK_EN: defined -> heartbeat frames with nonzero [63:35] are rejected (no field update, no status_valid_o, no counter/timeout clear) and increment frame_err_cnt_o; undefined -> reserved bits ignored, all heartbeats accepted, heartbeat contributions to frame_err_cnt_o are zero.

Verification
REQ-016 Bench (CLK_PER_MS=10, TIMEOUT_MS=5) SHALL cover:
- Heartbeat data 64'h0000_0004_8F8A_BFFF -> 1 cycle later map_readback_cnt_o=9, main_scan_cnt_o=1, scan_state_o=15, laser_aom_voltage_o=12'hFFF, status_valid_o=1, link_alive_o=1, heartbeat_cnt_o=1.
- One heartbeat then silence 50 cycles -> link_lost_o single pulse, link_alive_o=0; next heartbeat -> link_alive_o=1.
- Heartbeat on same cycle as 5th ms tick -> no link_lost_o, link_alive_o stays 1.
- message_up_data_i=64'h0100_0000_0000_0001 -> fast_shutter_set_o=1, upd pulse; type 8'd2 -> no upd, frame_err_cnt_o=1.
- With HEARTBEAT_RESERVED_CHECK_EN, data bit 63 set -> fields unchanged, frame_err_cnt_o increments; without -> frame accepted.
- rst_i asserted while ALIVE with heartbeat_cnt_o=3 -> all outputs 0, IDLE, no timeout after 100 cycles.
